uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 78 +++++++
 tb/tb_uart_tx_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: arbitrates two character sources onto one UART transmitter,
// bounding bursts per requester and flagging a transmitter that never answers.
`timescale 1ns/1ps
module uart_tx_sched #(
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   parameter int TIMEOUT   = 1023
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req0_valid_i,
   input  logic [DATA_W-1:0] req0_data_i,
   output logic              req0_ready_o,
   input  logic              req1_valid_i,
   input  logic [DATA_W-1:0] req1_data_i,
   output logic              req1_ready_o,
   output logic              tx_start_o,
   output logic [DATA_W-1:0] tx_data_o,
   input  logic              tx_busy_i,
   input  logic              tx_done_i,
   output logic [1:0]        grant_o,
   input  logic              clr_err_i,
   output logic              err_timeout_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
   state_t      state, state_d;
   logic        last_grant;
   logic [3:0]  burst_cnt;
   logic [15:0] tmo_cnt;
   logic        keep, sel1, accept, tmo, release_grant;
   assign keep   = burst_cnt < 4'(MAX_BURST);
   // sel1 picks requester 1; on a tie the last owner keeps the line until its burst is spent
   assign sel1   = req1_valid_i & (~req0_valid_i | (last_grant ? keep : ~keep));
   assign req0_ready_o  = rst_ni & (state == IDLE) & req0_valid_i & ~sel1;
   assign req1_ready_o  = rst_ni & (state == IDLE) & sel1;
   assign accept        = req0_ready_o | req1_ready_o;
   assign tmo           = (state == WAIT_BUSY) & ~tx_done_i & ~tx_busy_i & (tmo_cnt == 16'(TIMEOUT - 1));
   assign tx_start_o    = state == ISSUE;
   assign release_grant = (state == WAIT_BUSY || state == WAIT_DONE) && state_d == IDLE;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state <= IDLE;
      else state <= state_d;
   always_comb begin
      state_d = state;
      case (state)
         IDLE:      state_d = accept ? ISSUE : IDLE;
         ISSUE:     state_d = WAIT_BUSY;
         WAIT_BUSY: state_d = (tx_done_i || tmo) ? IDLE : tx_busy_i ? WAIT_DONE : WAIT_BUSY;
         WAIT_DONE: state_d = tx_done_i ? IDLE : WAIT_DONE;
         default:   state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         tx_data_o     <= '0;
         grant_o       <= '0;
         err_timeout_o <= 1'b0;
         tmo_cnt       <= '0;
         last_grant    <= 1'b1;
         burst_cnt     <= 4'(MAX_BURST);
      end else begin
         if (accept) begin
            tx_data_o <= sel1 ? req1_data_i : req0_data_i;
            grant_o   <= {sel1, ~sel1};
            if (sel1 == last_grant) begin
               burst_cnt <= (burst_cnt >= 4'(MAX_BURST)) ? 4'(MAX_BURST) : burst_cnt + 4'd1;
            end else begin
               last_grant <= sel1;
               burst_cnt  <= 4'd1;
            end
         end else if (release_grant) begin
            grant_o <= '0;
         end
         tmo_cnt <= (state == WAIT_BUSY) ? tmo_cnt + 16'd1 : '0;
         if (tmo) err_timeout_o <= 1'b1;
         else if (clr_err_i) err_timeout_o <= 1'b0;
      end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: queue-driven requesters, a transmitter model and a
// scoreboard monitor that checks grant/data on every tx_start_o pulse.
`timescale 1ns/1ps
module tb_uart_tx_sched;
   logic       clk = 1'b0, rst_ni = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
   logic [7:0] req0_data = '0, req1_data = '0, tx_data;
   logic       tx_start, tx_busy = 1'b0, tx_done = 1'b0, clr_err = 1'b0, err;
   logic [1:0] grant;
   int         total = 0, bad = 0, mode = 0, mcyc = 0;
   logic [7:0] q0[$], q1[$];
   logic [9:0] exp_q[$];
   int         starts[$];
   always #5 clk = ~clk;
   uart_tx_sched #(.DATA_W(8), .MAX_BURST(4), .TIMEOUT(15)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_ready_o(req0_ready),
      .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_ready_o(req1_ready),
      .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy), .tx_done_i(tx_done),
      .grant_o(grant), .clr_err_i(clr_err), .err_timeout_o(err)
   );
   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask
   task automatic send(int r, logic [7:0] d);
      if (r == 0) q0.push_back(d);
      else q1.push_back(d);
   endtask
   task automatic expect_char(int r, logic [7:0] d);
      exp_q.push_back({(r == 0) ? 2'b01 : 2'b10, d});
   endtask
   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL drain: %0d characters still expected after 300 cycles", exp_q.size());
         q0.delete();
         q1.delete();
         exp_q.delete();
      end
      repeat (8) @(negedge clk);
   endtask
   task automatic wait_start();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #3;
         if (tx_start) return;
      end
      total++;
      bad++;
      $display("FAIL wait_start: no tx_start_o within 40 cycles, required one");
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0;
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      #3;
   endtask
   // requester driver: present queue heads, pop on handshake
   initial forever begin
      @(negedge clk);
      req0_valid = (q0.size() != 0);
      req0_data  = req0_valid ? q0[0] : 8'h00;
      req1_valid = (q1.size() != 0);
      req1_data  = req1_valid ? q1[0] : 8'h00;
      #1;
      if (req0_valid && req0_ready) void'(q0.pop_front());
      if (req1_valid && req1_ready) void'(q1.pop_front());
   end
   // transmitter model: mode 0 busy 3 cycles then done, 1 silent, 2 done without busy
   initial forever begin
      @(negedge clk);
      if (tx_start) begin
         if (mode == 0) begin
            @(negedge clk);
            tx_busy = 1'b1;
            repeat (3) @(negedge clk);
            tx_busy = 1'b0;
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
         end else if (mode == 2) begin
            @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
         end
      end
   end
   // scoreboard monitor
   initial forever begin
      logic [9:0] e;
      @(negedge clk);
      mcyc++;
      #2;
      if (tx_start) begin
         starts.push_back(mcyc);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_start: got data %0h grant %0b, required no start", tx_data, grant);
         end else begin
            e = exp_q.pop_front();
            check("sb_grant", 32'(grant), 32'(e[9:8]));
            check("sb_data", 32'(tx_data), 32'(e[7:0]));
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      send(0, 8'h55);
      repeat (3) @(negedge clk);
      #3;
      check("rst_ready0", 32'(req0_ready), 0);
      check("rst_start", 32'(tx_start), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_data", 32'(tx_data), 0);
      check("rst_err", 32'(err), 0);
      q0.delete();
      @(negedge clk);
      rst_ni = 1'b1;
      #3;
      send(0, 8'h41);
      expect_char(0, 8'h41);
      @(negedge clk);
      #2;
      check("ready0_same_cycle", 32'(req0_ready), 1);
      check("ready1_low", 32'(req1_ready), 0);
      check("start_not_yet", 32'(tx_start), 0);
      @(negedge clk);
      #3;
      check("first_start", 32'(tx_start), 1);
      check("first_grant", 32'(grant), 32'b01);
      check("first_data", 32'(tx_data), 32'h41);
      @(negedge clk);
      #3;
      check("start_one_cycle", 32'(tx_start), 0);
      check("grant_held", 32'(grant), 32'b01);
      check("data_held", 32'(tx_data), 32'h41);
      drain();
      check("grant_released", 32'(grant), 0);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         send(0, 8'(8'h10 + i));
         send(1, 8'(8'h20 + i));
      end
      for (int i = 0; i < 4; i++) expect_char(0, 8'(8'h10 + i));
      for (int i = 0; i < 4; i++) expect_char(1, 8'(8'h20 + i));
      for (int i = 4; i < 6; i++) expect_char(0, 8'(8'h10 + i));
      for (int i = 4; i < 6; i++) expect_char(1, 8'(8'h20 + i));
      drain();
      do_reset();
      starts.delete();
      for (int i = 0; i < 10; i++) begin
         send(1, 8'(8'h30 + i));
         expect_char(1, 8'(8'h30 + i));
      end
      drain();
      check("b2b_count", 32'(starts.size()), 10);
      for (int i = 1; i < 10 && i < starts.size(); i++) check("b2b_gap", 32'(starts[i] - starts[i-1]), 6);
      send(0, 8'h50);
      send(1, 8'h51);
      expect_char(0, 8'h50);
      expect_char(1, 8'h51);
      drain();
      do_reset();
      mode = 1;
      send(0, 8'h60);
      expect_char(0, 8'h60);
      wait_start();
      repeat (15) @(negedge clk);
      #3;
      check("tmo_not_early", 32'(err), 0);
      check("grant_in_wait", 32'(grant), 32'b01);
      @(negedge clk);
      #3;
      check("tmo_set", 32'(err), 1);
      check("tmo_grant_clear", 32'(grant), 0);
      mode = 2;
      send(1, 8'h61);
      expect_char(1, 8'h61);
      drain();
      check("err_sticky", 32'(err), 1);
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      #3;
      check("err_cleared", 32'(err), 0);
      mode = 1;
      clr_err = 1'b1;
      send(0, 8'h62);
      expect_char(0, 8'h62);
      wait_start();
      repeat (16) @(negedge clk);
      #3;
      check("set_wins", 32'(err), 1);
      @(negedge clk);
      #3;
      check("clr_after_set", 32'(err), 0);
      clr_err = 1'b0;
      mode = 2;
      send(0, 8'h63);
      expect_char(0, 8'h63);
      wait_start();
      @(negedge clk);
      #3;
      check("fast_done_grant_held", 32'(grant), 32'b01);
      @(negedge clk);
      #3;
      check("fast_done_release", 32'(grant), 0);
      repeat (20) @(negedge clk);
      #3;
      check("fast_done_no_tmo", 32'(err), 0);
      mode = 0;
      send(1, 8'h64);
      expect_char(1, 8'h64);
      wait_start();
      repeat (3) @(negedge clk);
      #1;
      rst_ni = 1'b0;
      #1;
      check("async_rst_grant", 32'(grant), 0);
      check("async_rst_data", 32'(tx_data), 0);
      #1;
      rst_ni = 1'b1;
      repeat (10) @(negedge clk);
      #3;
      check("stale_done_grant", 32'(grant), 0);
      check("stale_done_data", 32'(tx_data), 0);
      send(0, 8'h65);
      expect_char(0, 8'h65);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
